// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus layouts, select/command
// codes and the store handshake state encoding.
package mem_stage_pkg;

    localparam int EXE_MEM_BUS_W = 187;
    localparam int MEM_WB_BUS_W  = 115;
    localparam int MEM_ID_BUS_W  = 38;

    localparam logic [2:0] WB_SEL_ALU = 3'd0;
    localparam logic [2:0] WB_SEL_LD  = 3'd1;
    localparam logic [2:0] WB_SEL_PC4 = 3'd2;
    localparam logic [2:0] WB_SEL_CSR = 3'd3;

    localparam logic [3:0] CSR_CMD_NONE = 4'd0;
    localparam logic [3:0] CSR_CMD_W    = 4'd1;
    localparam logic [3:0] CSR_CMD_S    = 4'd2;
    localparam logic [3:0] CSR_CMD_C    = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } st_state_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [31:0] st_data;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
        logic [31:0] op1;
        logic [31:0] ld_data;
    } exe_mem_bus_t;

    function automatic logic [31:0] wb_select(
        input logic [2:0]  sel,
        input logic [31:0] alu_result,
        input logic [31:0] ld_data,
        input logic [31:0] pc,
        input logic [31:0] csr_rdata
    );
        logic [31:0] v;
        case (sel)
            WB_SEL_ALU: v = alu_result;
            WB_SEL_LD:  v = ld_data;
            WB_SEL_PC4: v = pc + 32'd4;
            WB_SEL_CSR: v = csr_rdata;
            default:    v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_stage_csr_alu.sv
// CSR read-modify-write data and write enable for the entry held in the stage.
module mem_csr_alu
    import mem_stage_pkg::*;
(
    input  logic        ms_valid,
    input  logic [3:0]  csr_cmd,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] op1,
    output logic        csr_we,
    output logic [31:0] csr_wdata
);

    always_comb begin
        csr_we    = 1'b0;
        csr_wdata = 32'd0;
        case (csr_cmd)
            CSR_CMD_W: begin
                csr_we    = ms_valid;
                csr_wdata = op1;
            end
            // set/clear with an all-zero mask would rewrite the same value
            CSR_CMD_S: begin
                csr_we    = ms_valid && (op1 != 32'd0);
                csr_wdata = csr_rdata | op1;
            end
            CSR_CMD_C: begin
                csr_we    = ms_valid && (op1 != 32'd0);
                csr_wdata = csr_rdata & ~op1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, runs the store
// req/ack handshake and builds the writeback and forwarding buses.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no store in flight; a latched store moves to REQ next cycle
// ST_REQ  | mem_wr_req high, waiting for ack (or timeout)
// ST_DONE | store finished, entry may leave when downstream accepts
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int STORE_TIMEOUT = 0
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXE_MEM_BUS_W-1:0] exe_mem_bus_in,
    input  logic                     es_to_ms_valid,
    output logic                     ms_allowin,
    input  logic                     ws_allowin,
    output logic                     ms_to_ws_valid,
    output logic                     mem_wr_req,
    output logic [31:0]              mem_wr_addr,
    output logic [31:0]              mem_wr_data,
    input  logic                     mem_wr_ack,
    output logic                     mem_err,
    input  logic [31:0]              csr_rdata,
    output logic [MEM_WB_BUS_W-1:0]  mem_wb_bus_out,
    output logic [MEM_ID_BUS_W-1:0]  mem_id_data_bus
);

    localparam int CNT_W = (STORE_TIMEOUT > 1) ? $clog2(STORE_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STORE_TIMEOUT);

    exe_mem_bus_t     bus_r;
    logic             ms_valid;
    st_state_t        st_state;
    logic [CNT_W-1:0] st_cnt;
    logic [CNT_W-1:0] st_cnt_nxt;
    logic             ms_ready_go;
    logic [31:0]      wb_value;
    logic             rd_wen_g;
    logic             csr_we;
    logic [31:0]      csr_wdata;
    logic             unused_mem_re;

    assign ms_ready_go    = !bus_r.mem_we || (st_state == ST_DONE);
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign st_cnt_nxt     = st_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
            st_state <= ST_IDLE;
            st_cnt   <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid && ms_allowin)
                bus_r <= exe_mem_bus_t'(exe_mem_bus_in);

            case (st_state)
                ST_IDLE: begin
                    if (ms_valid && bus_r.mem_we) begin
                        st_state <= ST_REQ;
                        st_cnt   <= '0;
                    end
                end
                // an ack arriving on the timeout cycle still completes cleanly
                ST_REQ: begin
                    if (mem_wr_ack) begin
                        st_state <= ST_DONE;
                    end else if (STORE_TIMEOUT != 0 && st_cnt_nxt == CNT_LIMIT) begin
                        mem_err  <= 1'b1;
                        st_state <= ST_DONE;
                    end else begin
                        st_cnt <= st_cnt_nxt;
                    end
                end
                ST_DONE: begin
                    if (ws_allowin)
                        st_state <= ST_IDLE;
                end
                default: st_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_wr_req  = (st_state == ST_REQ);
    assign mem_wr_addr = bus_r.alu_result;
    assign mem_wr_data = bus_r.st_data;

    mem_csr_alu u_csr_alu (
        .ms_valid  (ms_valid),
        .csr_cmd   (bus_r.csr_cmd),
        .csr_rdata (csr_rdata),
        .op1       (bus_r.op1),
        .csr_we    (csr_we),
        .csr_wdata (csr_wdata)
    );

    assign wb_value = wb_select(bus_r.wb_sel, bus_r.alu_result, bus_r.ld_data,
                                bus_r.pc, csr_rdata);
    assign rd_wen_g = bus_r.rd_wen & ms_valid;

    assign mem_wb_bus_out  = {wb_value, bus_r.rd, rd_wen_g, csr_we, bus_r.csr_addr,
                              csr_wdata, bus_r.pc};
    assign mem_id_data_bus = {wb_value, rd_wen_g, bus_r.rd};

    assign unused_mem_re = bus_r.mem_re;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard; a second instance
// with a store timeout covers the error path.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [186:0] bus_in = '0;
    logic         es_valid = 1'b0;
    logic         es_valid1 = 1'b0;
    logic         ws_allowin = 1'b1;
    logic         ack0 = 1'b0;
    logic         ack1 = 1'b0;
    logic [31:0]  csr_rdata = '0;

    logic         allowin0, valid0, req0, err0;
    logic [31:0]  addr0, data0;
    logic [114:0] wb0;
    logic [37:0]  fwd0;
    logic         allowin1, valid1, req1, err1;
    logic [31:0]  addr1, data1;
    logic [114:0] wb1;
    logic [37:0]  fwd1;

    typedef struct {
        logic [114:0] wb;
        logic [37:0]  fwd;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage dut0 (
        .clk(clk), .rst(rst), .exe_mem_bus_in(bus_in), .es_to_ms_valid(es_valid),
        .ms_allowin(allowin0), .ws_allowin(ws_allowin), .ms_to_ws_valid(valid0),
        .mem_wr_req(req0), .mem_wr_addr(addr0), .mem_wr_data(data0),
        .mem_wr_ack(ack0), .mem_err(err0), .csr_rdata(csr_rdata),
        .mem_wb_bus_out(wb0), .mem_id_data_bus(fwd0)
    );

    mem_stage #(.STORE_TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .exe_mem_bus_in(bus_in), .es_to_ms_valid(es_valid1),
        .ms_allowin(allowin1), .ws_allowin(ws_allowin), .ms_to_ws_valid(valid1),
        .mem_wr_req(req1), .mem_wr_addr(addr1), .mem_wr_data(data1),
        .mem_wr_ack(ack1), .mem_err(err1), .csr_rdata(csr_rdata),
        .mem_wb_bus_out(wb1), .mem_id_data_bus(fwd1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks a retiring entry against the scoreboard, then advances one clock.
    task automatic cycle();
        exp_t e;
        #1;
        if (valid0 && ws_allowin) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_underflow observed=retire expected=none");
            end else begin
                e = sb.pop_front();
                chk("sb_wb_bus", wb0, e.wb);
                chk("sb_fwd_bus", fwd0, e.fwd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [186:0] mk_bus(
        input logic [31:0] alu, input logic [4:0] rd, input logic rd_wen, input logic we,
        input logic [2:0] wsel, input logic [31:0] pc, input logic [31:0] st,
        input logic [3:0] cmd, input logic [11:0] caddr, input logic [31:0] op1,
        input logic [31:0] ld);
        return {alu, rd, rd_wen, we, 1'b0, wsel, pc, st, cmd, caddr, op1, ld};
    endfunction

    task automatic send(
        input logic [31:0] alu, input logic [4:0] rd, input logic rd_wen, input logic we,
        input logic [2:0] wsel, input logic [31:0] pc, input logic [31:0] st,
        input logic [3:0] cmd, input logic [11:0] caddr, input logic [31:0] op1,
        input logic [31:0] ld, input bit push);
        exp_t        e;
        logic [31:0] v;
        logic        cwe;
        logic [31:0] cwd;
        case (wsel)
            3'd0:    v = alu;
            3'd1:    v = ld;
            3'd2:    v = pc + 32'd4;
            3'd3:    v = csr_rdata;
            default: v = 32'd0;
        endcase
        cwe = 1'b0;
        cwd = 32'd0;
        case (cmd)
            4'd1: begin cwe = 1'b1;           cwd = op1;               end
            4'd2: begin cwe = (op1 != 32'd0); cwd = csr_rdata | op1;  end
            4'd3: begin cwe = (op1 != 32'd0); cwd = csr_rdata & ~op1; end
            default: ;
        endcase
        e.wb  = {v, rd, rd_wen, cwe, caddr, cwd, pc};
        e.fwd = {v, rd_wen, rd};
        if (push)
            sb.push_back(e);
        bus_in   = mk_bus(alu, rd, rd_wen, we, wsel, pc, st, cmd, caddr, op1, ld);
        es_valid = 1'b1;
        cycle();
        es_valid = 1'b0;
    endtask

    initial begin
        // reset
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_allowin", allowin0, 1);
        chk("rst_valid", valid0, 0);
        chk("rst_req", req0, 0);
        chk("rst_err", err0, 0);
        chk("rst_wb_bus", wb0, 0);
        chk("rst_fwd_bus", fwd0, 0);
        chk("rst_addr", addr0, 0);

        // plain ALU op, one-cycle residency
        send(32'h1234, 5'd5, 1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 4'd0, 12'h0, 32'h0, 32'h0, 1);
        chk("alu_valid", valid0, 1);
        chk("alu_fwd", fwd0, {32'h1234, 1'b1, 5'd5});
        cycle();
        chk("alu_gone", valid0, 0);
        chk("alu_fwd_gated", fwd0, {32'h1234, 1'b0, 5'd5});

        // ack while idle has no effect
        ack0 = 1'b1;
        cycle();
        ack0 = 1'b0;
        chk("stray_ack_req", req0, 0);
        chk("stray_ack_allowin", allowin0, 1);

        // store, ack on the fourth request cycle
        send(32'h80, 5'd0, 1'b0, 1'b1, 3'd0, 32'h200, 32'hDEADBEEF, 4'd0, 12'h0, 32'h0, 32'h0, 1);
        chk("st_req_lat", req0, 0);
        chk("st_allowin_lat", allowin0, 0);
        cycle();
        chk("st_addr", addr0, 32'h80);
        chk("st_data", data0, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            chk("st_req_held", req0, 1);
            chk("st_allowin_held", allowin0, 0);
            chk("st_valid_held", valid0, 0);
            if (i == 3) ack0 = 1'b1;
            cycle();
            ack0 = 1'b0;
        end
        chk("st_req_drop", req0, 0);
        chk("st_valid_out", valid0, 1);
        cycle();

        // store acked immediately, downstream stalled in DONE
        send(32'h84, 5'd0, 1'b0, 1'b1, 3'd0, 32'h204, 32'h0BADF00D, 4'd0, 12'h0, 32'h0, 32'h0, 1);
        cycle();
        chk("st2_req", req0, 1);
        ack0 = 1'b1;
        ws_allowin = 1'b0;
        cycle();
        ack0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_valid", valid0, 1);
            chk("stall_req", req0, 0);
            chk("stall_allowin", allowin0, 0);
            chk("stall_wb_value", wb0[114:83], 32'h84);
            cycle();
        end
        ws_allowin = 1'b1;
        cycle();
        chk("st2_retired", valid0, 0);

        // CSR clear, set, write and a zero-mask clear
        csr_rdata = 32'hFF;
        send(32'h0, 5'd7, 1'b1, 1'b0, 3'd3, 32'h300, 32'h0, 4'd3, 12'h305, 32'h0F, 32'h0, 1);
        chk("csrc_wdata", wb0[63:32], 32'hF0);
        chk("csrc_we", wb0[76], 1);
        chk("csrc_waddr", wb0[75:64], 12'h305);
        send(32'h0, 5'd7, 1'b1, 1'b0, 3'd3, 32'h304, 32'h0, 4'd3, 12'h305, 32'h0, 32'h0, 1);
        chk("csrc_zero_we", wb0[76], 0);
        send(32'h0, 5'd8, 1'b1, 1'b0, 3'd3, 32'h308, 32'h0, 4'd2, 12'h340, 32'h100, 32'h0, 1);
        chk("csrs_wdata", wb0[63:32], 32'h1FF);
        send(32'h0, 5'd9, 1'b0, 1'b0, 3'd0, 32'h30C, 32'h0, 4'd1, 12'h341, 32'hCAFE0000, 32'h0, 1);
        chk("csrw_we", wb0[76], 1);

        // writeback selects, pc+4 wrap, unused select code
        send(32'h1, 5'd1, 1'b1, 1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 4'd0, 12'h0, 32'h0, 32'h0, 1);
        chk("pc4_wrap", wb0[114:83], 32'h0);
        send(32'h1, 5'd2, 1'b1, 1'b0, 3'd1, 32'h400, 32'h0, 4'd0, 12'h0, 32'h0, 32'h55AA55AA, 1);
        chk("ld_sel", fwd0[37:6], 32'h55AA55AA);
        send(32'h1, 5'd3, 1'b1, 1'b0, 3'd5, 32'h404, 32'h0, 4'd0, 12'h0, 32'h0, 32'h7, 1);
        chk("bad_sel", fwd0[37:6], 32'h0);
        cycle();

        // reset in the middle of a request
        send(32'h90, 5'd0, 1'b0, 1'b1, 3'd0, 32'h500, 32'h12345678, 4'd0, 12'h0, 32'h0, 32'h0, 0);
        cycle();
        chk("rstreq_req", req0, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rstreq_req_drop", req0, 0);
        chk("rstreq_allowin", allowin0, 1);
        chk("rstreq_valid", valid0, 0);

        // timeout instance: ack never comes
        bus_in    = mk_bus(32'hA0, 5'd0, 1'b0, 1'b1, 3'd0, 32'h600, 32'h1, 4'd0, 12'h0, 32'h0, 32'h0);
        es_valid1 = 1'b1;
        cycle();
        es_valid1 = 1'b0;
        chk("to_req_lat", req1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("to_req", req1, 1);
            chk("to_err_early", err1, 0);
        end
        chk("to_addr", addr1, 32'hA0);
        chk("to_data", data1, 32'h1);
        cycle();
        chk("to_err", err1, 1);
        chk("to_valid", valid1, 1);
        chk("to_req_drop", req1, 0);
        chk("to_wb_value", wb1[114:83], 32'hA0);
        chk("to_fwd", fwd1, {32'hA0, 1'b0, 5'd0});
        cycle();
        chk("to_retired", allowin1, 1);
        chk("to_err_sticky", err1, 1);
        chk("dut0_no_err", err0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("to_err_clear", err1, 0);

        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
